// File: rtl/hazard_pkg.sv
// Shared types for the mMIPS hazard/forwarding controller: forward codes,
// control FSM states and the packed pipeline-control bundle.
package hazard_pkg;

  // EX operand source selected by the registered forward code
  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_e;

  typedef enum logic [1:0] {
    StRun   = 2'b00,
    StFlush = 2'b01,
    StHold  = 2'b10
  } state_e;

  localparam int unsigned FLUSH_CNT_W = 3;

  // sll r0,r0,0 is what IF/ID and ID/EX load when flushed or bubbled
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_bubble;
    logic pipe_en;
    logic imem_en;
  } ctl_t;

  localparam ctl_t CTL_IDLE  = 6'b000000;
  localparam ctl_t CTL_RESET = 6'b000100;
  localparam ctl_t CTL_RUN   = 6'b110011;
  localparam ctl_t CTL_STALL = 6'b000111;
  localparam ctl_t CTL_FLUSH = 6'b111111;

endpackage

// File: rtl/hazard_fwd_unit_if.sv
// Pipeline <-> hazard unit bundle. Signal prefixes are from the hazard unit's
// point of view: i_ = into the unit, o_ = driven by the unit.
interface hazard_fwd_unit_if #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned NUM_RD = 2,
  parameter int unsigned CNT_W  = 32
);
  logic                     i_enable;
  logic [NUM_RD*REG_AW-1:0] i_id_src_addr;
  logic [NUM_RD-1:0]        i_id_src_used;
  logic                     i_idex_regwr;
  logic                     i_idex_memrd;
  logic [REG_AW-1:0]        i_idex_wr_addr;
  logic                     i_exmem_regwr;
  logic [REG_AW-1:0]        i_exmem_wr_addr;
  logic                     i_ex_br_taken;
  logic                     i_dmem_wait;
  logic                     i_imem_wait;

  logic                     o_pc_write;
  logic                     o_ifid_write;
  logic                     o_ifid_flush;
  logic                     o_idex_bubble;
  logic                     o_pipe_en;
  logic                     o_imem_en;
  logic [NUM_RD*2-1:0]      o_fwd_sel;
  logic [CNT_W-1:0]         o_perf_loaduse;
  logic [CNT_W-1:0]         o_perf_flush;
  logic [CNT_W-1:0]         o_perf_memwait;

  modport master (
    output i_enable, i_id_src_addr, i_id_src_used, i_idex_regwr, i_idex_memrd,
           i_idex_wr_addr, i_exmem_regwr, i_exmem_wr_addr, i_ex_br_taken,
           i_dmem_wait, i_imem_wait,
    input  o_pc_write, o_ifid_write, o_ifid_flush, o_idex_bubble, o_pipe_en,
           o_imem_en, o_fwd_sel, o_perf_loaduse, o_perf_flush, o_perf_memwait
  );

  modport slave (
    input  i_enable, i_id_src_addr, i_id_src_used, i_idex_regwr, i_idex_memrd,
           i_idex_wr_addr, i_exmem_regwr, i_exmem_wr_addr, i_ex_br_taken,
           i_dmem_wait, i_imem_wait,
    output o_pc_write, o_ifid_write, o_ifid_flush, o_idex_bubble, o_pipe_en,
           o_imem_en, o_fwd_sel, o_perf_loaduse, o_perf_flush, o_perf_memwait
  );
endinterface

// File: rtl/hazard_src_cmp.sv
// Compares one ID source operand against the ID/EX and EX/MEM destinations and
// produces the match bits plus the forward code for that operand.
module hazard_src_cmp
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW = 5
) (
  input  logic [REG_AW-1:0] i_src_addr,
  input  logic              i_src_used,
  input  logic              i_idex_regwr,
  input  logic [REG_AW-1:0] i_idex_wr_addr,
  input  logic              i_exmem_regwr,
  input  logic [REG_AW-1:0] i_exmem_wr_addr,
  output logic              o_match_idex,
  output logic              o_match_exmem,
  output fwd_e              o_fwd
);

  logic w_src_live;

  // r0 is hardwired to zero, so it never depends on an older writer
  assign w_src_live    = i_src_used && (i_src_addr != '0);
  assign o_match_idex  = w_src_live && i_idex_regwr && (i_src_addr == i_idex_wr_addr);
  assign o_match_exmem = w_src_live && i_exmem_regwr && (i_src_addr == i_exmem_wr_addr);

  always_comb begin
    o_fwd = FWD_RF;
    if (o_match_idex) begin
      o_fwd = FWD_EXMEM;
    end else if (o_match_exmem) begin
      o_fwd = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Hazard detection, operand forwarding, branch squash and memory-wait freeze for
// the 5-stage mMIPS pipeline. Optional counters: define HAZARD_PERF_CNT_EN.
module hazard_fwd_unit
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned NUM_RD     = 2,
  parameter int unsigned BR_PENALTY = 1,
  parameter int unsigned CNT_W      = 32
) (
  input logic               clk,
  input logic               rst,
  hazard_fwd_unit_if.slave  io_hz
);

  logic [NUM_RD-1:0]      w_match_idex;
  logic [NUM_RD-1:0]      w_match_exmem;
  logic [NUM_RD*2-1:0]    w_fwd;
  logic                   w_loaduse;
  logic                   w_wait;
  logic                   w_flushing;
  state_e                 w_eff_state;
  state_e                 w_state_nxt;
  state_e                 w_ret_nxt;
  logic [FLUSH_CNT_W-1:0] w_cnt_nxt;
  ctl_t                   w_ctl;

  state_e                 r_state;
  state_e                 r_ret_state;
  logic [FLUSH_CNT_W-1:0] r_cnt;
  logic [NUM_RD*2-1:0]    r_fwd_sel;

  for (genvar g = 0; g < NUM_RD; g++) begin : g_cmp
    fwd_e w_code;
    hazard_src_cmp #(
      .REG_AW (REG_AW)
    ) u_cmp (
      .i_src_addr      (io_hz.i_id_src_addr[g*REG_AW +: REG_AW]),
      .i_src_used      (io_hz.i_id_src_used[g]),
      .i_idex_regwr    (io_hz.i_idex_regwr),
      .i_idex_wr_addr  (io_hz.i_idex_wr_addr),
      .i_exmem_regwr   (io_hz.i_exmem_regwr),
      .i_exmem_wr_addr (io_hz.i_exmem_wr_addr),
      .o_match_idex    (w_match_idex[g]),
      .o_match_exmem   (w_match_exmem[g]),
      .o_fwd           (w_code)
    );
    assign w_fwd[g*2 +: 2] = w_code;
  end

  assign w_loaduse   = io_hz.i_idex_memrd && (|w_match_idex);
  assign w_wait      = io_hz.i_dmem_wait || io_hz.i_imem_wait;
  // While held, the pipe behaves as the state it was frozen in
  assign w_eff_state = (r_state == StHold) ? r_ret_state : r_state;
  assign w_flushing  = (w_eff_state == StFlush) && (r_cnt != '0);

  always_comb begin
    w_ctl       = CTL_RUN;
    w_state_nxt = r_state;
    w_ret_nxt   = r_ret_state;
    w_cnt_nxt   = r_cnt;
    if (rst) begin
      w_ctl = CTL_RESET;
    end else if (!io_hz.i_enable) begin
      w_ctl             = CTL_IDLE;
      w_ctl.idex_bubble = w_loaduse;
    end else if (w_wait) begin
      w_ctl         = CTL_IDLE;
      w_ctl.imem_en = !io_hz.i_dmem_wait;
      w_state_nxt   = StHold;
      w_ret_nxt     = w_eff_state;
    end else if (io_hz.i_ex_br_taken) begin
      w_ctl       = CTL_FLUSH;
      w_state_nxt = StFlush;
      w_cnt_nxt   = FLUSH_CNT_W'(BR_PENALTY - 1);
    end else if (w_flushing) begin
      w_ctl       = CTL_FLUSH;
      w_state_nxt = StFlush;
      w_cnt_nxt   = r_cnt - 1'b1;
    end else begin
      w_state_nxt = StRun;
      if (w_loaduse) begin
        w_ctl = CTL_STALL;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StRun;
      r_ret_state <= StRun;
      r_cnt       <= '0;
      r_fwd_sel   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_ret_state <= w_ret_nxt;
      r_cnt       <= w_cnt_nxt;
      if (w_ctl.pipe_en) begin
        r_fwd_sel <= w_ctl.idex_bubble ? '0 : w_fwd;
      end
    end
  end

  assign io_hz.o_pc_write    = w_ctl.pc_write;
  assign io_hz.o_ifid_write  = w_ctl.ifid_write;
  assign io_hz.o_ifid_flush  = w_ctl.ifid_flush;
  assign io_hz.o_idex_bubble = w_ctl.idex_bubble;
  assign io_hz.o_pipe_en     = w_ctl.pipe_en;
  assign io_hz.o_imem_en     = w_ctl.imem_en;
  assign io_hz.o_fwd_sel     = r_fwd_sel;

`ifdef HAZARD_PERF_CNT_EN
  logic             w_evt_loaduse;
  logic             w_evt_flush;
  logic             w_evt_memwait;
  logic [CNT_W-1:0] r_perf_loaduse;
  logic [CNT_W-1:0] r_perf_flush;
  logic [CNT_W-1:0] r_perf_memwait;

  // CTL_STALL and ifid_flush only appear while enabled and not waiting
  assign w_evt_loaduse = (w_ctl == CTL_STALL);
  assign w_evt_flush   = w_ctl.ifid_flush;
  assign w_evt_memwait = !rst && io_hz.i_enable && w_wait;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_loaduse <= '0;
      r_perf_flush   <= '0;
      r_perf_memwait <= '0;
    end else begin
      if (w_evt_loaduse && (r_perf_loaduse != '1)) r_perf_loaduse <= r_perf_loaduse + 1'b1;
      if (w_evt_flush && (r_perf_flush != '1))     r_perf_flush   <= r_perf_flush + 1'b1;
      if (w_evt_memwait && (r_perf_memwait != '1)) r_perf_memwait <= r_perf_memwait + 1'b1;
    end
  end

  assign io_hz.o_perf_loaduse = r_perf_loaduse;
  assign io_hz.o_perf_flush   = r_perf_flush;
  assign io_hz.o_perf_memwait = r_perf_memwait;
`else
  assign io_hz.o_perf_loaduse = {CNT_W{1'b0}};
  assign io_hz.o_perf_flush   = {CNT_W{1'b0}};
  assign io_hz.o_perf_memwait = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed bench for hazard_fwd_unit: forwarding, load-use, branch squash,
// memory wait, enable freeze and reset, with hand-computed expectations.
module tb_hazard_fwd_unit;
  localparam int unsigned REG_AW     = 5;
  localparam int unsigned NUM_RD     = 2;
  localparam int unsigned BR_PENALTY = 2;
  localparam int unsigned CNT_W      = 32;
`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF_EN = 1'b1;
`else
  localparam bit PERF_EN = 1'b0;
`endif

  // {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_en, imem_en}
  localparam logic [5:0] C_RST   = 6'b000100;
  localparam logic [5:0] C_RUN   = 6'b110011;
  localparam logic [5:0] C_STALL = 6'b000111;
  localparam logic [5:0] C_FLUSH = 6'b111111;
  localparam logic [5:0] C_DWAIT = 6'b000000;
  localparam logic [5:0] C_IWAIT = 6'b000001;
  localparam logic [5:0] C_OFF   = 6'b000000;
  localparam logic [5:0] C_OFFLU = 6'b000100;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  hazard_fwd_unit_if #(.REG_AW(REG_AW), .NUM_RD(NUM_RD), .CNT_W(CNT_W)) hz ();

  hazard_fwd_unit #(
    .REG_AW     (REG_AW),
    .NUM_RD     (NUM_RD),
    .BR_PENALTY (BR_PENALTY),
    .CNT_W      (CNT_W)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .io_hz (hz)
  );

  function automatic logic [5:0] ctl();
    return {hz.o_pc_write, hz.o_ifid_write, hz.o_ifid_flush,
            hz.o_idex_bubble, hz.o_pipe_en, hz.o_imem_en};
  endfunction

  function automatic logic [31:0] perf(input int n);
    return PERF_EN ? 32'(n) : 32'd0;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    hz.i_enable        = 1'b1;
    hz.i_id_src_addr   = '0;
    hz.i_id_src_used   = '0;
    hz.i_idex_regwr    = 1'b0;
    hz.i_idex_memrd    = 1'b0;
    hz.i_idex_wr_addr  = '0;
    hz.i_exmem_regwr   = 1'b0;
    hz.i_exmem_wr_addr = '0;
    hz.i_ex_br_taken   = 1'b0;
    hz.i_dmem_wait     = 1'b0;
    hz.i_imem_wait     = 1'b0;
  endtask

  task automatic set_id(input logic [4:0] s1, input logic [4:0] s0, input logic [1:0] used);
    hz.i_id_src_addr = {s1, s0};
    hz.i_id_src_used = used;
  endtask

  task automatic set_idex(input logic regwr, input logic memrd, input logic [4:0] a);
    hz.i_idex_regwr   = regwr;
    hz.i_idex_memrd   = memrd;
    hz.i_idex_wr_addr = a;
  endtask

  task automatic set_exmem(input logic regwr, input logic [4:0] a);
    hz.i_exmem_regwr   = regwr;
    hz.i_exmem_wr_addr = a;
  endtask

  initial begin
    rst = 1'b1;
    quiet();
    #1;
    check("rst_ctl", ctl(), C_RST);
    tick();
    check("rst_fwd", hz.o_fwd_sel, 4'b0000);
    check("rst_perf_lu", hz.o_perf_loaduse, 0);
    rst = 1'b0;
    #1;
    check("idle_ctl", ctl(), C_RUN);

    // add r3 ; sub r4,r3,r5
    set_idex(1, 0, 3); set_id(5, 3, 2'b11); #1;
    check("addsub_nostall", ctl(), C_RUN);
    tick();
    check("addsub_fwd", hz.o_fwd_sel, 4'b0001);
    set_idex(0, 0, 0); set_exmem(1, 3); set_id(0, 0, 2'b00);
    tick();
    check("unused_fwd", hz.o_fwd_sel, 4'b0000);

    // op1 from ID/EX, op0 from EX/MEM; then ID/EX priority on both
    set_idex(1, 0, 7); set_exmem(1, 5); set_id(7, 5, 2'b11); #1;
    check("mix_ctl", ctl(), C_RUN);
    tick();
    check("mix_fwd", hz.o_fwd_sel, 4'b0110);
    set_exmem(1, 7); set_id(7, 7, 2'b11);
    tick();
    check("prio_fwd", hz.o_fwd_sel, 4'b0101);

    // lw r2 ; add r6,r2,r2
    set_exmem(0, 0); set_idex(1, 1, 2); set_id(2, 2, 2'b11); #1;
    check("lu_stall", ctl(), C_STALL);
    tick();
    check("lu_bubble_fwd", hz.o_fwd_sel, 4'b0000);
    set_idex(0, 0, 0); set_exmem(1, 2); #1;
    check("lu_release", ctl(), C_RUN);
    tick();
    check("lu_fwd", hz.o_fwd_sel, 4'b1010);
    check("lu_perf", hz.o_perf_loaduse, perf(1));

    // r0 never matches, even behind a load
    set_idex(1, 1, 0); set_exmem(1, 0); set_id(0, 0, 2'b11); #1;
    check("r0_nostall", ctl(), C_RUN);
    tick();
    check("r0_fwd", hz.o_fwd_sel, 4'b0000);
    set_idex(1, 1, 4); set_exmem(0, 0); set_id(4, 4, 2'b00); #1;
    check("unused_nostall", ctl(), C_RUN);
    set_id(4, 9, 2'b10); #1;
    check("lu_op1", ctl(), C_STALL);
    tick();
    check("lu_perf2", hz.o_perf_loaduse, perf(2));

    // taken branch, BR_PENALTY = 2
    quiet(); hz.i_ex_br_taken = 1'b1; #1;
    check("br_first", ctl(), C_FLUSH);
    tick(); hz.i_ex_br_taken = 1'b0; #1;
    check("br_second", ctl(), C_FLUSH);
    tick(); #1;
    check("br_done", ctl(), C_RUN);
    check("br_perf", hz.o_perf_flush, perf(2));

    // branch beats a load-use stall
    set_idex(1, 1, 6); set_id(0, 6, 2'b01); hz.i_ex_br_taken = 1'b1; #1;
    check("br_over_lu", ctl(), C_FLUSH);
    tick(); quiet(); #1;
    check("br_over_lu2", ctl(), C_FLUSH);
    tick(); #1;
    check("br_over_lu_done", ctl(), C_RUN);
    check("lu_not_counted", hz.o_perf_loaduse, perf(2));

    // second branch inside FLUSH reloads the counter
    hz.i_ex_br_taken = 1'b1;
    tick(); #1;
    check("br_reload_hit", ctl(), C_FLUSH);
    tick(); hz.i_ex_br_taken = 1'b0; #1;
    check("br_reload", ctl(), C_FLUSH);
    tick(); #1;
    check("br_reload_done", ctl(), C_RUN);

    // dmem wait in the middle of a flush
    hz.i_ex_br_taken = 1'b1;
    tick(); hz.i_ex_br_taken = 1'b0; hz.i_dmem_wait = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("dwait_%0d", i), ctl(), C_DWAIT);
      tick();
    end
    hz.i_dmem_wait = 1'b0; #1;
    check("dwait_resume", ctl(), C_FLUSH);
    tick(); #1;
    check("dwait_done", ctl(), C_RUN);
    check("flush_perf", hz.o_perf_flush, perf(9));
    check("dwait_perf", hz.o_perf_memwait, perf(3));

    // imem wait keeps imem_en and holds fwd_sel
    set_idex(1, 0, 3); set_id(0, 3, 2'b01); hz.i_imem_wait = 1'b1; #1;
    check("iwait_ctl", ctl(), C_IWAIT);
    tick();
    check("iwait_fwd_held", hz.o_fwd_sel, 4'b0000);
    hz.i_imem_wait = 1'b0; #1;
    check("iwait_release", ctl(), C_RUN);
    tick();
    check("iwait_fwd_after", hz.o_fwd_sel, 4'b0001);
    check("iwait_perf", hz.o_perf_memwait, perf(4));

    // enable = 0 freezes the FSM and fwd_sel, bubble mirrors load-use
    hz.i_enable = 1'b0; set_idex(1, 1, 3); hz.i_ex_br_taken = 1'b1; #1;
    check("off_bubble", ctl(), C_OFFLU);
    tick();
    check("off_fwd_held", hz.o_fwd_sel, 4'b0001);
    set_idex(0, 0, 0); #1;
    check("off_idle", ctl(), C_OFF);
    tick();
    hz.i_enable = 1'b1; hz.i_ex_br_taken = 1'b0; #1;
    check("off_no_flush", ctl(), C_RUN);
    check("off_perf_lu", hz.o_perf_loaduse, perf(2));
    check("off_perf_fl", hz.o_perf_flush, perf(9));

    // reset clears fwd_sel
    set_idex(1, 0, 3); set_id(0, 3, 2'b01);
    tick();
    check("pre_rst_fwd", hz.o_fwd_sel, 4'b0001);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_fwd_clear", hz.o_fwd_sel, 4'b0000);

    // reset in the middle of a flush
    quiet(); hz.i_ex_br_taken = 1'b1;
    tick(); hz.i_ex_br_taken = 1'b0; rst = 1'b1; #1;
    check("rst_in_flush", ctl(), C_RST);
    tick(); rst = 1'b0; #1;
    check("rst_to_run", ctl(), C_RUN);
    check("rst_perf_lu0", hz.o_perf_loaduse, 0);
    check("rst_perf_fl0", hz.o_perf_flush, 0);
    check("rst_perf_mw0", hz.o_perf_memwait, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
